// File: rtl/isqrt_pipe_with_valid.sv
// Fully pipelined integer square root, one result bit per stage, valid carried alongside data.
// Data registers only load on a valid beat, so outputs hold the last result across bubbles.
module isqrt_pipe_with_valid #(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  input  logic [width-1:0]   in_data,
  output logic               out_vld,
  output logic [width/2-1:0] out_data,
  output logic [width/2:0]   out_rem
);

  localparam int N = width / 2;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    localparam int B = N - 1 - gi;

    logic             vld_reg;
    logic [width-1:0] x_reg;
    logic [N-1:0]     root_reg;
    logic [N+1:0]     rem_reg;

    logic             vld_prev;
    logic [width-1:0] x_prev;
    logic [N-1:0]     root_prev;
    logic [N+1:0]     rem_prev;
    logic [N+1:0]     r2;
    logic [N+1:0]     t;
    logic             ge;

    if (gi == 0) begin : g_first
      assign vld_prev  = in_vld;
      assign x_prev    = in_data;
      assign root_prev = '0;
      assign rem_prev  = '0;
    end else begin : g_next
      assign vld_prev  = g_stage[gi-1].vld_reg;
      assign x_prev    = g_stage[gi-1].x_reg;
      assign root_prev = g_stage[gi-1].root_reg;
      assign rem_prev  = g_stage[gi-1].rem_reg;
    end

    // rem <= 2*root keeps the shifted remainder within N+2 bits.
    assign r2 = (rem_prev << 2) | {{N{1'b0}}, x_prev[2*B+1 -: 2]};
    assign t  = {root_prev, 2'b01};
    assign ge = (r2 >= t);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg  <= 1'b0;
        x_reg    <= '0;
        root_reg <= '0;
        rem_reg  <= '0;
      end else begin
        vld_reg <= vld_prev;
        if (vld_prev) begin
          x_reg    <= x_prev;
          root_reg <= {root_prev[N-2:0], ge};
          rem_reg  <= ge ? (r2 - t) : r2;
        end
      end
    end
  end

  assign out_vld  = g_stage[N-1].vld_reg;
  assign out_data = g_stage[N-1].root_reg;
  assign out_rem  = g_stage[N-1].rem_reg[N:0];

  // Final remainder MSB is always zero and the last stage's radicand is fully consumed.
  logic unused_tail;
  assign unused_tail = g_stage[N-1].rem_reg[N+1] ^ (^g_stage[N-1].x_reg);

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Scoreboard bench for isqrt_pipe_with_valid at width 32, plus exhaustive sweeps at widths 8 and 4.
module tb_isqrt_pipe_with_valid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld32 = 1'b0, vld8 = 1'b0, vld4 = 1'b0;
  logic [31:0] in32 = '0;
  logic [7:0]  in8 = '0;
  logic [3:0]  in4 = '0;
  logic        ovld32, ovld8, ovld4;
  logic [15:0] od32;
  logic [16:0] or32;
  logic [3:0]  od8;
  logic [4:0]  or8;
  logic [1:0]  od4;
  logic [2:0]  or4;

  always #5 clk = ~clk;

  isqrt_pipe_with_valid #(.width(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld32), .in_data(in32),
    .out_vld(ovld32), .out_data(od32), .out_rem(or32));
  isqrt_pipe_with_valid #(.width(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld8), .in_data(in8),
    .out_vld(ovld8), .out_data(od8), .out_rem(or8));
  isqrt_pipe_with_valid #(.width(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(vld4), .in_data(in4),
    .out_vld(ovld4), .out_data(od4), .out_rem(or4));

  typedef struct {
    longint unsigned x;
    longint unsigned root;
    longint unsigned rem;
    int              due;
  } exp_t;

  exp_t sb32[512];
  exp_t sb8[512];
  exp_t sb4[512];
  int wr32 = 0, rd32 = 0, wr8 = 0, rd8 = 0, wr4 = 0, rd4 = 0;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  longint unsigned hold32_d = 0, hold32_r = 0, hold8_d = 0, hold8_r = 0, hold4_d = 0, hold4_r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: floor(sqrt(x)) from real sqrt, corrected with exact integer arithmetic.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic exp_t mk(input longint unsigned x, input int lat);
    exp_t e;
    e.x    = x;
    e.root = isqrt(x);
    e.rem  = x - e.root * e.root;
    e.due  = cyc + lat;
    return e;
  endfunction

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: out_vld with empty scoreboard (cyc %0d)", name, cyc);
  endfunction

  // Monitor: pops expected results whenever a DUT presents out_vld.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd32 = wr32; rd8 = wr8; rd4 = wr4;
      hold32_d = 0; hold32_r = 0; hold8_d = 0; hold8_r = 0; hold4_d = 0; hold4_r = 0;
    end else begin
      if (ovld32) begin
        if (rd32 == wr32) fail_now("w32_unexpected_vld");
        else begin
          chk("w32_root", od32, sb32[rd32].root);
          chk("w32_rem", or32, sb32[rd32].rem);
          chk("w32_latency", cyc, sb32[rd32].due);
          $display("w32 x=%08h root=%0d rem=%0d cyc=%0d", sb32[rd32].x, od32, or32, cyc);
          hold32_d = sb32[rd32].root; hold32_r = sb32[rd32].rem;
          rd32++;
        end
      end else begin
        chk("w32_hold_data", od32, hold32_d);
        chk("w32_hold_rem", or32, hold32_r);
      end
      if (ovld8) begin
        if (rd8 == wr8) fail_now("w8_unexpected_vld");
        else begin
          chk("w8_root", od8, sb8[rd8].root);
          chk("w8_rem", or8, sb8[rd8].rem);
          chk("w8_latency", cyc, sb8[rd8].due);
          $display("w8 x=%0d root=%0d rem=%0d cyc=%0d", sb8[rd8].x, od8, or8, cyc);
          hold8_d = sb8[rd8].root; hold8_r = sb8[rd8].rem;
          rd8++;
        end
      end else begin
        chk("w8_hold_data", od8, hold8_d);
        chk("w8_hold_rem", or8, hold8_r);
      end
      if (ovld4) begin
        if (rd4 == wr4) fail_now("w4_unexpected_vld");
        else begin
          chk("w4_root", od4, sb4[rd4].root);
          chk("w4_rem", or4, sb4[rd4].rem);
          chk("w4_latency", cyc, sb4[rd4].due);
          $display("w4 x=%0d root=%0d rem=%0d cyc=%0d", sb4[rd4].x, od4, or4, cyc);
          hold4_d = sb4[rd4].root; hold4_r = sb4[rd4].rem;
          rd4++;
        end
      end else begin
        chk("w4_hold_data", od4, hold4_d);
        chk("w4_hold_rem", or4, hold4_r);
      end
    end
  end

  // Drive one cycle of stimulus; called 1ns after a rising edge.
  task automatic step(input logic v32, input logic [31:0] d32,
                      input logic v8, input logic [7:0] d8,
                      input logic v4, input logic [3:0] d4);
    vld32 = v32; in32 = d32;
    vld8  = v8;  in8  = d8;
    vld4  = v4;  in4  = d4;
    if (v32) begin sb32[wr32] = mk(d32, 16); wr32++; end
    if (v8)  begin sb8[wr8]   = mk(d8, 4);   wr8++;  end
    if (v4)  begin sb4[wr4]   = mk(d4, 2);   wr4++;  end
    @(posedge clk); #1;
  endtask

  task automatic send32(input logic v, input logic [31:0] d);
    step(v, d, 1'b0, 8'($urandom), 1'b0, 4'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send32(1'b0, $urandom);
  endtask

  logic [31:0] dir_vals [8] = '{32'd0, 32'd1, 32'd2, 32'd15, 32'd16, 32'd24,
                                32'hFFFF_FFFF, 32'hFFFE_0001};
  logic        bub_pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_vld32", ovld32, 0);
    chk("reset_out_data32", od32, 0);
    chk("reset_out_rem32", or32, 0);
    chk("reset_out_vld8", ovld8, 0);
    chk("reset_out_vld4", ovld4, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single transfers including extremes.
    foreach (dir_vals[i]) begin
      send32(1'b1, dir_vals[i]);
      idle(2);
    end
    idle(20);

    // Back-to-back random.
    for (int i = 0; i < 64; i++) send32(1'b1, $urandom);
    idle(20);

    // Bubble pattern.
    foreach (bub_pat[i]) send32(bub_pat[i], $urandom);
    idle(20);

    // Random valid density.
    for (int i = 0; i < 100; i++) send32(1'($urandom_range(0, 1)), $urandom);
    idle(20);

    // Reset mid-flight with results streaming out.
    for (int i = 0; i < 24; i++) send32(1'b1, $urandom);
    vld32 = 1'b0;
    chk("pre_reset_out_vld", ovld32, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_out_vld", ovld32, 0);
    chk("async_reset_out_data", od32, 0);
    chk("async_reset_out_rem", or32, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(20);
    send32(1'b1, 32'd49);
    idle(20);

    // Exhaustive sweeps at widths 8 and 4.
    for (int i = 0; i < 256; i++)
      step(1'b0, $urandom, 1'b1, 8'(i), (i < 16), 4'(i));
    idle(20);

    chk("w32_drain", rd32, wr32);
    chk("w8_drain", rd8, wr8);
    chk("w4_drain", rd4, wr4);
    chk("w8_count", wr8, 256);
    chk("w4_count", wr4, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
